// File: rtl/cpu_bus_timing.sv
// cpu_bus_timing: master-clock timing for 65816 bus cycles, producing cpu_en, bus strobes and DMA/refresh stalls.
// The address is sampled at cnt=0, so bus strobes and bus_addr reflect the new cycle from cnt=1 onward.
module cpu_bus_timing #(
  parameter int FAST_LEN    = 6,
  parameter int SLOW_LEN    = 8,
  parameter int XSLOW_LEN   = 12,
  parameter int REFRESH_LEN = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] mem_addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        memsel,
  input  logic        halt,
  input  logic        refresh_req,
  output logic        cpu_en,
  output logic [23:0] bus_addr,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic        halted,
  output logic [3:0]  cycle_len
);
  typedef enum logic [1:0] {RUN, HALT, REFRESH} state_t;
  localparam logic [3:0] FL = 4'(FAST_LEN);
  localparam logic [3:0] SL = 4'(SLOW_LEN);
  localparam logic [3:0] XL = 4'(XSLOW_LEN);
  localparam logic [5:0] RL = 6'(REFRESH_LEN - 1);
  state_t      state;
  logic [5:0]  cnt, nxt, last;
  logic [3:0]  len, rom_len;
  logic [15:0] off;
  logic        rd, rd_l, wr_l, pend;
  assign off     = mem_addr[15:0];
  assign rd      = mem_read && !mem_write;
  assign rom_len = mem_addr[23] && memsel ? FL : SL;
  // Banks $40-$7F/$C0-$FF and the upper half of system banks share the FastROM rule.
  assign len  = !(mem_read || mem_write) ? FL :
                (mem_addr[22] || off[15]) ? rom_len :
                off < 16'h2000 ? SL :
                off < 16'h4000 ? FL :
                off < 16'h4200 ? XL :
                off < 16'h6000 ? FL : SL;
  assign nxt  = cnt + 6'd1;
  assign last = {2'b00, cycle_len} - 6'd1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      cnt       <= '0;
      cpu_en    <= 1'b0;
      bus_rd    <= 1'b0;
      bus_wr    <= 1'b0;
      halted    <= 1'b0;
      bus_addr  <= '0;
      cycle_len <= FL;
      rd_l      <= 1'b0;
      wr_l      <= 1'b0;
      pend      <= 1'b0;
    end else begin
      // A request arriving while refresh starts re-arms the flag for another refresh.
      pend <= refresh_req || (pend && !(state == RUN && cnt == 6'd0));
      case (state)
        RUN:
          if (cnt == 6'd0) begin
            if (pend) state <= REFRESH;
            else if (halt) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              cnt       <= 6'd1;
              bus_addr  <= mem_addr;
              cycle_len <= len;
              rd_l      <= rd;
              wr_l      <= mem_write;
              bus_rd    <= rd;
            end
          end else if (cnt == last) begin
            cnt    <= '0;
            cpu_en <= 1'b0;
            bus_rd <= 1'b0;
            bus_wr <= 1'b0;
          end else begin
            cnt    <= nxt;
            cpu_en <= nxt == last;
            bus_rd <= rd_l;
            bus_wr <= wr_l && nxt >= 6'd2;
          end
        HALT:
          if (!halt) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        default:
          if (cnt == RL) begin
            cnt   <= '0;
            state <= RUN;
          end else cnt <= nxt;
      endcase
    end
  end
endmodule

// File: doc/cpu_bus_timing.md
Name: cpu_bus_timing

Overview:
- Master-clock bus timing stage between the 65816 core and the system bus.
- Each CPU bus cycle, it samples the core's address and read/write request and looks up the access length in master clocks (6, 8 or 12) from the console memory-speed map.
- It generates the single-cycle cpu_en pulse that advances the core, and qualified bus strobes for downstream devices.
- It also stalls the core for DMA (halt) and DRAM refresh windows.

Parameters:
- FAST_LEN, 6, master clocks for a fast access and for internal (no read/write) cycles.
- SLOW_LEN, 8, master clocks for a slow access.
- XSLOW_LEN, 12, master clocks for an extra-slow access.
- REFRESH_LEN, 40, master clocks the core is held per refresh request.

Ports:
- clk  in  1  master clock
- reset  in  1  asynchronous, active-high reset
- mem_addr  in  24  core address, stable between cpu_en pulses
- mem_read  in  1  core read request
- mem_write  in  1  core write request
- memsel  in  1  FastROM enable (MEMSEL bit 0)
- halt  in  1  DMA stall request, level
- refresh_req  in  1  DRAM refresh request, single-cycle pulse
- cpu_en  out  1  one-clk pulse on the last master clock of each core cycle
- bus_addr  out  24  address latched at cycle start
- bus_rd  out  1  read strobe
- bus_wr  out  1  write strobe
- halted  out  1  core held for DMA
- cycle_len  out  4  length of the current cycle (debug)

Behaviour:
- Reset (async) values:
  - state=RUN, cnt=0
  - cpu_en=0, bus_rd=0, bus_wr=0, halted=0
  - bus_addr=0, cycle_len=FAST_LEN
  - refresh pending flag cleared
  - Reset mid-cycle aborts the cycle with no cpu_en pulse. The first cycle starts on the first clk after reset deasserts.
- Speed map, evaluated on mem_addr at cycle start. bank = addr[23:16], off = addr[15:0].
  - bank $00-$3F or $80-$BF:
    - off $0000-$1FFF = SLOW
    - off $2000-$3FFF = FAST
    - off $4000-$41FF = XSLOW
    - off $4200-$5FFF = FAST
    - off $6000-$7FFF = SLOW
    - off $8000-$FFFF = FAST if bank[7] and memsel, else SLOW
  - bank $40-$7F = SLOW.
  - bank $C0-$FF = FAST if memsel, else SLOW.
  - Neither mem_read nor mem_write (internal cycle) = FAST_LEN regardless of address.
  - mem_read and mem_write both high is illegal; treat as write.
- States:
  - RUN:
    - At cnt=0, latch bus_addr, length L and request type.
    - cnt increments each clk.
    - cpu_en=1 exactly when cnt=L-1; cnt then returns to 0.
    - bus_rd = latched read for cnt in 1..L-1.
    - bus_wr = latched write for cnt in 2..L-1 (one clock of address setup).
    - Both strobes are 0 at cnt=0 and on internal cycles.
    - Each L-clock cycle produces exactly one cpu_en.
  - HALT:
    - Entered instead of starting a new cycle when halt=1 at the cycle boundary (clk after the cpu_en pulse, or from reset).
    - halted=1, cpu_en=0, strobes 0.
    - Exit when halt=0; the next clk starts a new RUN cycle with cnt=0.
    - halt rising mid-cycle does not shorten the cycle: the cycle completes and its cpu_en fires, then HALT is entered.
  - REFRESH:
    - refresh_req sets a pending flag.
    - At the next cycle boundary the block holds for REFRESH_LEN clocks, cpu_en=0, then clears the flag.
    - If halt and refresh are both pending at a boundary, REFRESH goes first, then halt is re-evaluated.
    - halt arriving during REFRESH takes effect at REFRESH end.
    - A refresh_req during REFRESH or HALT stays pending; it is serviced when the current HALT ends, or after the current REFRESH ends.
    - Multiple refresh_req pulses before service merge into one.
- cycle_len: updated at cnt=0 in RUN; holds its value in HALT and REFRESH.
- cnt width: 6 bits, enough for REFRESH_LEN. Values are compared exactly; there is no wrap inside a cycle.
- Latency: the address becomes visible on bus_addr at the clk following the previous cpu_en.

Test Plan:
- mem_addr=$7E0010, mem_read=1 -> cpu_en pulses every 8 clks; bus_rd high on cnt 1..7; cycle_len=8.
- mem_addr=$808000, read, memsel=1 -> period 6. memsel=0 -> period 8. mem_addr=$008000 with memsel=1 -> period 8.
- mem_addr=$004016, write -> period 12; bus_wr high on cnt 2..11 only; bus_rd stays 0.
- No read/write at $000000 (internal cycle) -> period 6; bus_rd and bus_wr stay 0.
- halt raised at cnt=3 of an 8-clk cycle -> cpu_en still fires at cnt 7, then halted=1 with no cpu_en until halt=0; the next cpu_en comes 6/8/12 clks after exit.
- refresh_req during a cycle with halt also high -> 40 clks of no cpu_en, then HALT. reset asserted mid-REFRESH -> all outputs return to reset values immediately (async).
